// File: rtl/data_mem_initiator.sv
// Load/store initiator between the execute/memory stage and the data memory.
// Optional misaligned-access trap: define DATA_MEM_INITIATOR_MISALIGN_TRAP_EN.
module data_mem_initiator (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        misaligned_q, misaligned_d;
    logic        stall_seen_q, stall_seen_d;

    logic [3:0]  req_mask;
    logic        req_misaligned;

    // sign_mask: bit3 = sign-extend, low bits select byte/half/word lanes.
    always_comb begin
        case (req_funct3)
            3'b000:  req_mask = 4'b1001;
            3'b100:  req_mask = 4'b0001;
            3'b001:  req_mask = 4'b1011;
            3'b101:  req_mask = 4'b0011;
            default: req_mask = 4'b0111;
        endcase
    end

`ifdef DATA_MEM_INITIATOR_MISALIGN_TRAP_EN
    always_comb begin
        case (req_funct3)
            3'b000, 3'b100: req_misaligned = 1'b0;
            3'b001, 3'b101: req_misaligned = req_addr[0];
            default:        req_misaligned = |req_addr[1:0];
        endcase
    end
`else
    assign req_misaligned = 1'b0;
`endif

    // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        mask_d       = mask_q;
        misaligned_d = misaligned_q;
        stall_seen_d = stall_seen_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d      = req_store;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    mask_d       = req_mask;
                    misaligned_d = req_misaligned;
                    if (req_misaligned) begin
                        rdata_d = 32'h0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                stall_seen_d = 1'b0;
                state_d      = WAIT;
            end
            WAIT: begin
                if (!store_q) begin
                    rdata_d = mem_read_data;
                    state_d = RESP;
                end else if (mem_clk_stall) begin
                    stall_seen_d = 1'b1;
                end else if (stall_seen_q) begin
                    // A store only completes once the memory has stalled and released.
                    rdata_d = 32'h0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
            mask_q       <= 4'h0;
            misaligned_q <= 1'b0;
            stall_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            mask_q       <= mask_d;
            misaligned_q <= misaligned_d;
            stall_seen_q <= stall_seen_d;
        end
    end

    // Strobes are gated by reset so they drop in the same cycle reset rises.
    assign mem_memread     = (state_q == ISSUE) && !store_q && !reset;
    assign mem_memwrite    = (state_q == ISSUE) &&  store_q && !reset;
    assign mem_addr        = addr_q;
    assign mem_write_data  = wdata_q;
    assign mem_sign_mask   = mask_q;
    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = resp_valid && misaligned_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator with a behavioural data memory that
// stalls one cycle per store and places/extends lanes from sign_mask.
module tb_data_mem_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int resp_cnt = 0;
    int acc_cnt = 0;
    int busy_cnt = 0;
    int overlap_cnt = 0;

    data_mem_initiator dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_misaligned(resp_misaligned),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    always #5 clk = ~clk;

    // Behavioural data memory.
    logic [31:0] mem [0:1023] = '{default: 32'h0};

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] m, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        if (m[2])      r = wd;
        else if (m[1]) begin
            if (off[1]) r[31:16] = wd[15:0];
            else        r[15:0]  = wd[15:0];
        end else begin
            case (off)
                2'd0: r[7:0]   = wd[7:0];
                2'd1: r[15:8]  = wd[7:0];
                2'd2: r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [3:0] m,
                                                 input logic [1:0] off);
        logic [31:0] s;
        if (m[2]) return w;
        s = w >> (off * 8);
        if (m[1]) return m[3] ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
        return m[3] ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_memwrite) begin
            mem[mem_addr[11:2]] <= store_merge(mem[mem_addr[11:2]], mem_write_data,
                                               mem_sign_mask, mem_addr[1:0]);
            mem_clk_stall <= 1'b1;
        end else begin
            mem_clk_stall <= 1'b0;
        end
        if (mem_memread)
            mem_read_data <= load_extract(mem[mem_addr[11:2]], mem_sign_mask, mem_addr[1:0]);
    end

    // Activity monitor.
    always @(posedge clk) begin
        if (!reset) begin
            if (mem_memread || mem_memwrite) issue_cnt <= issue_cnt + 1;
            if (resp_valid)                  resp_cnt  <= resp_cnt + 1;
            if (req_valid && req_ready)      acc_cnt   <= acc_cnt + 1;
            if (!req_ready)                  busy_cnt  <= busy_cnt + 1;
            if (req_ready && (resp_valid || mem_memread || mem_memwrite))
                overlap_cnt <= overlap_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, return cycles from accept edge to resp_valid (-1 on timeout).
    // Returns at the negedge where resp_valid is high.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!resp_valid) lat = -1;
    endtask

    int          lat;
    int          i0, r0, a0, b0;
    logic        b_st   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] b_addr [4] = '{32'h300, 32'h300, 32'h304, 32'h304};
    logic [31:0] b_wd   [4] = '{32'hA5A50001, 32'h0, 32'h5A5A0002, 32'h0};

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0; req_wdata = 32'h0; mem_read_data = 32'h0; mem_clk_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_memread", {31'h0, mem_memread}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_sign_mask", {28'h0, mem_sign_mask}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_misaligned", {31'h0, resp_misaligned}, 32'h0);

        // Store then load of a full word.
        i0 = issue_cnt;
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat);
        check("sw_latency", lat, 32'd4);
        check("sw_rdata_zero", resp_rdata, 32'h0);
        check("sw_ready_in_resp", {31'h0, req_ready}, 32'h0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, lat);
        check("lw_latency", lat, 32'd3);
        check("lw_rdata", resp_rdata, 32'hDEADBEEF);
        check("sw_lw_issue_count", issue_cnt - i0, 32'd2);

        // Byte lane store and signed/unsigned byte loads.
        do_req(1'b1, 3'b010, 32'h100, 32'h11223344, lat);
        do_req(1'b1, 3'b000, 32'h101, 32'h000000A5, lat);
        check("sb_latency", lat, 32'd4);
        @(negedge clk);
        check("sb_hold_addr", mem_addr, 32'h101);
        check("sb_hold_wdata", mem_write_data, 32'h000000A5);
        check("sb_hold_mask", {28'h0, mem_sign_mask}, 32'h9);
        check("idle_memwrite", {31'h0, mem_memwrite}, 32'h0);
        do_req(1'b0, 3'b000, 32'h101, 32'h0, lat);
        check("lb_rdata", resp_rdata, 32'hFFFFFFA5);
        do_req(1'b0, 3'b100, 32'h101, 32'h0, lat);
        check("lbu_rdata", resp_rdata, 32'h000000A5);
        check("lbu_mask", {28'h0, mem_sign_mask}, 32'h1);
        repeat (2) @(negedge clk);
        check("rdata_hold", resp_rdata, 32'h000000A5);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, lat);
        check("lw_after_sb", resp_rdata, 32'h1122A544);

        // Halfword store and loads.
        do_req(1'b1, 3'b001, 32'h102, 32'h00008001, lat);
        check("sh_mask", {28'h0, mem_sign_mask}, 32'hB);
        do_req(1'b0, 3'b001, 32'h102, 32'h0, lat);
        check("lh_rdata", resp_rdata, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 32'h102, 32'h0, lat);
        check("lhu_rdata", resp_rdata, 32'h00008001);
        check("lhu_mask", {28'h0, mem_sign_mask}, 32'h3);
        do_req(1'b0, 3'b011, 32'h100, 32'h0, lat);
        check("f3_011_as_word", resp_rdata, 32'h8001A544);
        check("f3_011_mask", {28'h0, mem_sign_mask}, 32'h7);

        // Misaligned word/half access.
        i0 = issue_cnt;
`ifdef DATA_MEM_INITIATOR_MISALIGN_TRAP_EN
        do_req(1'b0, 3'b010, 32'h103, 32'h0, lat);
        check("mis_lw_latency", lat, 32'd1);
        check("mis_lw_flag", {31'h0, resp_misaligned}, 32'h1);
        check("mis_lw_rdata", resp_rdata, 32'h0);
        do_req(1'b0, 3'b001, 32'h101, 32'h0, lat);
        check("mis_lh_flag", {31'h0, resp_misaligned}, 32'h1);
        @(negedge clk);
        check("mis_no_strobe", issue_cnt - i0, 32'd0);
        check("mis_flag_drops", {31'h0, resp_misaligned}, 32'h0);
`else
        do_req(1'b0, 3'b010, 32'h103, 32'h0, lat);
        check("unal_lw_latency", lat, 32'd3);
        check("unal_lw_flag", {31'h0, resp_misaligned}, 32'h0);
        check("unal_lw_rdata", resp_rdata, 32'h8001A544);
        @(negedge clk);
        check("unal_issued", issue_cnt - i0, 32'd1);
`endif

        // Reset during the WAIT cycle of a store.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("wait_rst_issue_strobe", {31'h0, mem_memwrite}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        r0 = resp_cnt;
        @(negedge clk);
        reset = 1'b0;
        check("wait_rst_ready", {31'h0, req_ready}, 32'h1);
        check("wait_rst_no_resp", {31'h0, resp_valid}, 32'h0);
        repeat (3) @(negedge clk);
        check("wait_rst_no_resp_later", resp_cnt - r0, 32'd0);
        do_req(1'b0, 3'b010, 32'h200, 32'h0, lat);
        check("wait_rst_lw_data", resp_rdata, 32'hCAFEF00D);

        // Reset during ISSUE drops the strobe in the same cycle.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h204; req_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("issue_rst_strobe_drop", {31'h0, mem_memwrite}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("issue_rst_ready", {31'h0, req_ready}, 32'h1);
        do_req(1'b0, 3'b010, 32'h204, 32'h0, lat);
        check("issue_rst_no_write", resp_rdata, 32'h0);

        // Back-to-back requests with req_valid held high.
        @(negedge clk);
        i0 = issue_cnt; r0 = resp_cnt; a0 = acc_cnt; b0 = busy_cnt;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            req_store = b_st[k]; req_funct3 = 3'b010; req_addr = b_addr[k]; req_wdata = b_wd[k];
            n = 0;
            while (!req_ready && n < 20) begin @(negedge clk); n++; end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        check("b2b_last_latency", lat, 32'd3);
        check("b2b_last_rdata", resp_rdata, 32'h5A5A0002);
        @(negedge clk);
        check("b2b_accepts", acc_cnt - a0, 32'd4);
        check("b2b_issues", issue_cnt - i0, 32'd4);
        check("b2b_resps", resp_cnt - r0, 32'd4);
        check("b2b_busy_cycles", busy_cnt - b0, 32'd14);
        check("ready_overlap", overlap_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_initiator.md
# data_mem_initiator

Initiator-side controller that issues RV32I load/store transactions from the execute/memory pipeline stage to the data memory block. It registers one request at a time, drives the memory's address, data, strobe and sign_mask inputs, and honours the memory's clk_stall handshake. It returns load data, or store completion, to the pipeline as a one-cycle response pulse. Optionally, it detects and suppresses misaligned accesses.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline presents a memory operation
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse: load data valid or store complete
- resp_rdata  out  32  extended load data (0 for stores)
- resp_misaligned  out  1  qualifies resp_valid: access was misaligned and suppressed
- mem_addr  out  32  to data memory addr
- mem_write_data  out  32  to data memory write_data
- mem_memwrite  out  1  to data memory memwrite
- mem_memread  out  1  to data memory memread
- mem_sign_mask  out  4  to data memory sign_mask
- mem_read_data  in  32  from data memory read_data
- mem_clk_stall  in  1  from data memory clk_stall

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req_valid: register all req_* fields.
  - Compute sign_mask: B 4'b1001, BU 4'b0001, H 4'b1011, HU 4'b0011, W 4'b0111.
  - funct3 values 011, 110 and 111 are treated as W.
  - Go to ISSUE, or to RESP with misaligned=1 (see Configuration).
- ISSUE
  - mem_memread = ~store, mem_memwrite = store, for exactly this one cycle.
  - mem_addr, mem_write_data and mem_sign_mask carry the registered values.
  - Go to WAIT.
- WAIT, load: capture mem_read_data into resp_rdata; go to RESP.
- WAIT, store: stay while mem_clk_stall=1.
  - Go to RESP on the first cycle with mem_clk_stall=0, provided at least one stall cycle has been seen.
  - A sticky stall_seen flag is cleared in ISSUE.
- RESP: resp_valid=1 for one cycle; go to IDLE.
- mem_addr, mem_write_data and mem_sign_mask hold their last values outside ISSUE. Strobes are 0 outside ISSUE.
- Store data is passed unshifted; the memory performs lane placement. Loads are passed through; the memory performs sign/zero extension.
- resp_rdata holds its value until the next response and reads 0 for stores and misaligned responses.
- The LED address (32'h2000) is not special-cased; stores to it follow the normal store flow.

## Timing
- Reset (synchronous, active-high) puts every output to 0 except req_ready. req_ready is 1 from the first cycle after reset.
- Reset forces IDLE from any state and drops the strobes immediately.
  - A memory write already past its stall start still completes inside the memory.
  - No response is produced for it.
- Load latency: accept edge E0, ISSUE cycle, data sampled at E2, resp_valid in the cycle after E2. That is 3 cycles from accept to response; a new request can be accepted in the cycle after RESP.
- Store latency: ISSUE, stall observed after E1, stall low after E2, resp_valid after E3. That is 4 cycles.
- Misaligned response: resp_valid in the cycle after accept; no memory strobe is asserted.
- req_valid while req_ready=0 is ignored, not queued.
- The pipeline must hold req_* stable until accepted.
- resp_valid and req_ready are never high in the same cycle.

## Configuration
- DATA_MEM_INITIATOR_MISALIGN_TRAP_EN defined:
  - H/HU with addr[0]=1, or W with addr[1:0]≠0, goes IDLE→RESP with resp_misaligned=1.
  - resp_rdata=0 and mem strobes stay 0.
- Undefined:
  - resp_misaligned is tied to 0.
  - All accesses are issued unchanged; the data returned is whatever the memory produces for the given byte offset.

## Test plan
- LW 0x100 after SW 0x100 = 32'hDEADBEEF → store resp_valid 4 cycles after accept; load resp_valid 3 cycles after accept with resp_rdata = 32'hDEADBEEF.
- SB 0x101 = 32'h000000A5 to word 32'h11223344, then LB 0x101 → 32'hFFFFFFA5; LBU 0x101 → 32'h000000A5; LW 0x100 → 32'h1122A544.
- SH 0x102 = 32'h00008001, then LH 0x102 → 32'hFFFF8001; LHU 0x102 → 32'h00008001.
- With trap enabled, LW 0x103 → resp_valid next cycle with resp_misaligned=1, resp_rdata=0, mem_memread never high. With trap disabled, the access is issued and resp_misaligned=0.
- reset asserted in the WAIT cycle of a store → next cycle IDLE, req_ready=1, no resp_valid; a following LW to the same address returns the new data.
- req_valid held high continuously with alternating SW/LW → exactly one ISSUE strobe per accepted request; req_ready is low during ISSUE, WAIT and RESP.
